sram_1r1w_dly_model: RTL and testbench

Behavioural model of one physical 1r1w SRAM bank. It answers a single bank slice of the `t1_*` memory port driven by the multi-port algorithmic memory cores, so those cores can be simulated standalone. Port A is write-only and port B is read-only. Port B data returns after a programmable latency, with the write-through forward flag, single/double error flags and physical address the cores consume. A post-reset initialisation sweep and an error-injection port are included.

---
 rtl/sram_1r1w_dly_model.sv | 170 +++++++++++++++++
 tb/tb_sram_1r1w_dly_model.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_dly_model.sv
// sram_1r1w_dly_model: behavioural 1r1w SRAM bank with programmable read
// latency, write-through forwarding, injected error flags and a post-reset
// zeroing sweep.
module sram_1r1w_dly_model #(
    parameter int WIDTH   = 33,
    parameter int NUMADDR = 1024,
    parameter int BITADDR = 10,
    parameter int DELAY   = 1,
    parameter int BITPADR = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    input  logic               writeA,
    input  logic [BITADDR-1:0] addrA,
    input  logic [WIDTH-1:0]   dinA,
    input  logic               readB,
    input  logic [BITADDR-1:0] addrB,
    output logic [WIDTH-1:0]   doutB,
    output logic               fwrdB,
    output logic               serrB,
    output logic               derrB,
    output logic [BITPADR-1:0] padrB,
    input  logic               inj_serr,
    input  logic               inj_derr,
    input  logic [BITADDR-1:0] inj_adr
);

    localparam int IDXW = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;
    localparam logic [BITADDR:0]   NUM_W    = (BITADDR+1)'(NUMADDR);
    localparam logic [BITADDR-1:0] LAST_ROW = BITADDR'(NUMADDR - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    typedef struct packed {
        logic               vld;
        logic [WIDTH-1:0]   data;
        logic               fwrd;
        logic               serr;
        logic               derr;
        logic [BITPADR-1:0] padr;
    } slot_t;

    state_t             state_q, state_d;
    logic [BITADDR-1:0] icnt_q, icnt_d;
    slot_t              pipe_q [DELAY];
    slot_t              pipe_d [DELAY];
    slot_t              slot_new;
    slot_t              slot_out;

    logic [WIDTH-1:0]   mem_q [NUMADDR];
    logic [NUMADDR-1:0] serr_q;
    logic [NUMADDR-1:0] derr_q;

    logic               run;
    logic               mem_we;
    logic [IDXW-1:0]    mem_idx;
    logic [WIDTH-1:0]   mem_wdata;
    logic               inj_ok;
    logic [IDXW-1:0]    inj_idx;
    logic [IDXW-1:0]    rd_idx;
    logic               rd_inr;

    // Init sweep counter and state: walk every row once, then stay ready
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        if (state_q == ST_INIT) begin
            if (icnt_q == LAST_ROW) begin
                state_d = ST_READY;
            end else begin
                icnt_d = icnt_q + 1'b1;
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
        end
    end

    // Array write port: sweep zeroing during init, caller writes once ready
    always_comb begin
        run       = (state_q == ST_READY) && !rst;
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        inj_ok    = run && ({1'b0, inj_adr} < NUM_W);
        inj_idx   = inj_adr[IDXW-1:0];
        if (state_q == ST_INIT && !rst) begin
            mem_we  = 1'b1;
            mem_idx = icnt_q[IDXW-1:0];
        end else if (run && writeA && ({1'b0, addrA} < NUM_W)) begin
            mem_we    = 1'b1;
            mem_idx   = addrA[IDXW-1:0];
            mem_wdata = dinA;
        end
    end

    // Storage and flags; injection is applied last so it overrides a
    // same-row write clearing the flags in the same cycle
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx]  <= mem_wdata;
            serr_q[mem_idx] <= 1'b0;
            derr_q[mem_idx] <= 1'b0;
        end
        if (inj_ok && inj_serr) serr_q[inj_idx] <= 1'b1;
        if (inj_ok && inj_derr) derr_q[inj_idx] <= 1'b1;
    end

    // Build the new response slot and shift the latency pipeline
    always_comb begin
        slot_new = '0;
        rd_idx   = addrB[IDXW-1:0];
        rd_inr   = ({1'b0, addrB} < NUM_W);
        if (run && readB) begin
            slot_new.vld  = 1'b1;
            slot_new.padr = BITPADR'(addrB);
            if (rd_inr) begin
                if (writeA && (addrA == addrB)) begin
                    slot_new.data = dinA;
                    slot_new.fwrd = 1'b1;
                end else begin
                    slot_new.data = mem_q[rd_idx];
                    if (derr_q[rd_idx]) begin
                        slot_new.data[1:0] = ~slot_new.data[1:0];
                        slot_new.derr      = 1'b1;
                    end else if (serr_q[rd_idx]) begin
                        slot_new.data[0] = ~slot_new.data[0];
                        slot_new.serr    = 1'b1;
                    end
                end
            end
        end
        pipe_d[0] = slot_new;
        for (int unsigned i = 1; i < DELAY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Latency pipeline registers, flushed on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Output drive: empty slots present all zeros
    always_comb begin
        slot_out = pipe_q[DELAY-1];
        ready    = (state_q == ST_READY);
        doutB    = slot_out.vld ? slot_out.data : '0;
        fwrdB    = slot_out.vld & slot_out.fwrd;
        serrB    = slot_out.vld & slot_out.serr;
        derrB    = slot_out.vld & slot_out.derr;
        padrB    = slot_out.vld ? slot_out.padr : '0;
    end

endmodule

// File: tb/tb_sram_1r1w_dly_model.sv
// tb_sram_1r1w_dly_model: directed bench driving four banks (DELAY 1..4)
// from shared inputs, NUMADDR=16.
module tb_sram_1r1w_dly_model;

    logic        clk = 1'b0;
    logic        rst;
    logic        writeA, readB, inj_serr, inj_derr;
    logic [4:0]  addrA, addrB, inj_adr;
    logic [32:0] dinA;
    logic [3:0]  ready, fwrdB, serrB, derrB;
    logic [32:0] doutB [4];
    logic [5:0]  padrB [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sram_1r1w_dly_model #(
            .WIDTH(33), .NUMADDR(16), .BITADDR(5), .DELAY(g + 1), .BITPADR(6)
        ) u_dut (
            .clk(clk), .rst(rst), .ready(ready[g]),
            .writeA(writeA), .addrA(addrA), .dinA(dinA),
            .readB(readB), .addrB(addrB), .doutB(doutB[g]),
            .fwrdB(fwrdB[g]), .serrB(serrB[g]), .derrB(derrB[g]), .padrB(padrB[g]),
            .inj_serr(inj_serr), .inj_derr(inj_derr), .inj_adr(inj_adr)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        writeA = 1'b0; readB = 1'b0; inj_serr = 1'b0; inj_derr = 1'b0;
        addrA = '0; addrB = '0; inj_adr = '0; dinA = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] slot(input logic [32:0] d, input logic f, input logic s,
                                         input logic de, input logic [5:0] p);
        return {22'b0, d, f, s, de, p};
    endfunction

    function automatic logic [63:0] obs_slot(input int g);
        return {22'b0, doutB[g], fwrdB[g], serrB[g], derrB[g], padrB[g]};
    endfunction

    // Issue one read (with whatever write/inject inputs are already set) and
    // check every bank: the response appears exactly DELAY cycles later only.
    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [32:0] d,
                          input logic f, input logic s, input logic de);
        readB = 1'b1; addrB = a;
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < 4; g++) begin
                if (k == g)
                    chk($sformatf("%s_d%0d_resp", tag, g + 1), obs_slot(g), slot(d, f, s, de, 6'(a)));
                else
                    chk($sformatf("%s_d%0d_k%0d_empty", tag, g + 1, k), obs_slot(g), 64'd0);
            end
            tick();
        end
    endtask

    task automatic write_row(input logic [4:0] a, input logic [32:0] d);
        writeA = 1'b1; addrA = a; dinA = d;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int g = 0; g < 4; g++)
            chk($sformatf("reset_slot_d%0d", g + 1), obs_slot(g), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("init_ready_low_%0d", i), 64'(ready), 64'h0);
            tick();
        end
        chk("init_ready_high", 64'(ready), 64'hF);

        rd_chk("init_row5", 5'd5, 33'h0, 1'b0, 1'b0, 1'b0);

        // Write then read next cycle, checked at every latency
        write_row(5'd3, 33'h1_2345_6789);
        rd_chk("lat_row3", 5'd3, 33'h1_2345_6789, 1'b0, 1'b0, 1'b0);

        // Forwarding: same-cycle write+read, then plain read next cycle
        writeA = 1'b1; addrA = 5'd7; dinA = 33'hAA;
        readB = 1'b1; addrB = 5'd7;
        tick();
        idle();
        readB = 1'b1; addrB = 5'd7;
        chk("fwd_same", obs_slot(0), slot(33'hAA, 1'b1, 1'b0, 1'b0, 6'd7));
        tick();
        idle();
        chk("fwd_next", obs_slot(0), slot(33'hAA, 1'b0, 1'b0, 1'b0, 6'd7));
        chk("fwd_d2_same", obs_slot(1), slot(33'hAA, 1'b1, 1'b0, 1'b0, 6'd7));
        tick();
        tick();
        tick();

        // Error injection
        write_row(5'd9, 33'hF0);
        inj_serr = 1'b1; inj_adr = 5'd9;
        tick();
        idle();
        rd_chk("serr_row9", 5'd9, 33'hF1, 1'b0, 1'b1, 1'b0);
        inj_derr = 1'b1; inj_adr = 5'd9;
        tick();
        idle();
        rd_chk("derr_row9", 5'd9, 33'hF3, 1'b0, 1'b0, 1'b1);
        write_row(5'd9, 33'hF0);
        rd_chk("clean_row9", 5'd9, 33'hF0, 1'b0, 1'b0, 1'b0);

        // Injection wins over a same-row write in the same cycle
        writeA = 1'b1; addrA = 5'd10; dinA = 33'h55;
        inj_serr = 1'b1; inj_adr = 5'd10;
        tick();
        idle();
        rd_chk("inj_wins", 5'd10, 33'h54, 1'b0, 1'b1, 1'b0);

        // Back-to-back reads of rows 1,2,3
        write_row(5'd1, 33'h11);
        write_row(5'd2, 33'h22);
        readB = 1'b1; addrB = 5'd1;
        tick();
        addrB = 5'd2;
        chk("b2b_row1", obs_slot(0), slot(33'h11, 1'b0, 1'b0, 1'b0, 6'd1));
        tick();
        addrB = 5'd3;
        chk("b2b_row2", obs_slot(0), slot(33'h22, 1'b0, 1'b0, 1'b0, 6'd2));
        chk("b2b_row1_d2", obs_slot(1), slot(33'h11, 1'b0, 1'b0, 1'b0, 6'd1));
        tick();
        idle();
        chk("b2b_row3", obs_slot(0), slot(33'h1_2345_6789, 1'b0, 1'b0, 1'b0, 6'd3));
        tick();
        tick();
        tick();

        // Out of range: write must not alias onto row 0; read returns zeros
        write_row(5'd16, 33'h3FF);
        rd_chk("oor_read", 5'd16, 33'h0, 1'b0, 1'b0, 1'b0);
        rd_chk("oor_noalias_row0", 5'd0, 33'h0, 1'b0, 1'b0, 1'b0);

        // Reset one cycle after a read: no response, sweep restarts
        readB = 1'b1; addrB = 5'd3;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        writeA = 1'b1; addrA = 5'd4; dinA = 33'h44;
        readB = 1'b1; addrB = 5'd3;
        inj_serr = 1'b1; inj_adr = 5'd4;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) idle();
            chk($sformatf("rst_ready_low_%0d", i), 64'(ready), 64'h0);
            for (int g = 0; g < 4; g++)
                chk($sformatf("rst_flush_d%0d_%0d", g + 1, i), obs_slot(g), 64'd0);
            tick();
        end
        chk("rst_ready_high", 64'(ready), 64'hF);
        for (int g = 0; g < 4; g++)
            chk($sformatf("rst_after_d%0d", g + 1), obs_slot(g), 64'd0);
        rd_chk("rst_swept_row3", 5'd3, 33'h0, 1'b0, 1'b0, 1'b0);
        rd_chk("rst_ignored_row4", 5'd4, 33'h0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
